cart_upload: RTL and testbench

//  Read-back side of the cartridge ioctl path: serves hps_io upload requests by

---
 rtl/cart_upload.sv | 142 ++++++++++++++
 tb/tb_cart_upload.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cart_upload.sv
// cart_upload: read-back side of the cartridge ioctl path.
// Serves hps_io upload reads from cartridge RAM with wait back-pressure.
module cart_upload #(
   parameter int         ADDR_W    = 16,
   parameter int         CART_SIZE = 16384,
   parameter int         MEM_LAT   = 1,
   parameter logic [7:0] FILL      = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_dout,
   input  logic              mem_busy,
   output logic [ADDR_W-1:0] byte_count,
   output logic              err_overrun
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      LAT
   } state_t;

   // one extra bit so CART_SIZE == 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(CART_SIZE);
   localparam logic [1:0]        LAT_INIT = 2'(MEM_LAT);
   localparam logic [ADDR_W-1:0] CNT_MAX  = '1;

   state_t     state;
   logic [1:0] lat_cnt;
   logic       upload_q;

   logic       rise;
   logic       accept;
   logic       in_range;
   logic       fill_hit;
   logic       done;
   logic       inc;
   logic [ADDR_W-1:0] cnt_base;

   assign rise     = ioctl_upload & ~upload_q;
   assign in_range = {1'b0, ioctl_addr} < LIMIT;
   assign accept   = (state == IDLE) & ioctl_rd & ioctl_upload;
   assign fill_hit = accept & ~in_range;
   assign done     = (state == LAT) & ioctl_upload
                   & (lat_cnt == 2'd1);
   assign inc      = fill_hit | done;
   assign cnt_base = rise ? '0 : byte_count;

   // RAM strobe must follow the CPU's mem_busy in the same cycle
   assign mem_rd = (state == REQ) & ioctl_upload & ~mem_busy;

   // session edge detector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upload_q <= 1'b0;
      end else begin
         upload_q <= ioctl_upload;
      end
   end

   // read sequencer: accept, wait for RAM slot, count latency, return byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         lat_cnt    <= 2'd0;
         mem_addr   <= '0;
         ioctl_din  <= 8'h00;
         ioctl_wait <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mem_addr <= ioctl_addr;
                  if (in_range) begin
                     state      <= REQ;
                     ioctl_wait <= 1'b1;
                  end else begin
                     ioctl_din <= FILL;
                  end
               end
            end
            REQ: begin
               if (!ioctl_upload) begin
                  state      <= IDLE;
                  ioctl_wait <= 1'b0;
               end else if (!mem_busy) begin
                  state   <= LAT;
                  lat_cnt <= LAT_INIT;
               end
            end
            LAT: begin
               if (!ioctl_upload) begin
                  // abort: in-flight RAM data is dropped
                  state      <= IDLE;
                  ioctl_wait <= 1'b0;
               end else if (lat_cnt == 2'd1) begin
                  ioctl_din  <= mem_dout;
                  ioctl_wait <= 1'b0;
                  state      <= IDLE;
                  lat_cnt    <= 2'd0;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            default: begin
               state      <= IDLE;
               ioctl_wait <= 1'b0;
            end
         endcase
      end
   end

   // saturating per-session byte counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_count <= '0;
      end else if (inc && cnt_base != CNT_MAX) begin
         byte_count <= cnt_base + 1'b1;
      end else begin
         byte_count <= cnt_base;
      end
   end

   // sticky overrun flag, cleared at session start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_overrun <= 1'b0;
      end else if (rise) begin
         err_overrun <= 1'b0;
      end else if (ioctl_rd && ioctl_wait) begin
         err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cart_upload.sv
// tb_cart_upload: directed checks of cart_upload at MEM_LAT 1 and 3.
// Both instances share stimulus; each has its own RAM latency model.
module tb_cart_upload;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        upload = 1'b0;
   logic        rd = 1'b0;
   logic [15:0] addr = 16'h0;
   logic        busy = 1'b0;

   logic [7:0]  din1, din3, mdout1, mdout3;
   logic        wait1, wait3, mrd1, mrd3, err1, err3;
   logic [15:0] maddr1, maddr3, cnt1, cnt3;

   logic [7:0]  a1, b1, b2, b3;

   int vectors = 0;
   int miscompares = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   cart_upload #(.MEM_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset),
      .ioctl_upload(upload), .ioctl_rd(rd), .ioctl_addr(addr),
      .ioctl_din(din1), .ioctl_wait(wait1),
      .mem_addr(maddr1), .mem_rd(mrd1), .mem_dout(mdout1),
      .mem_busy(busy), .byte_count(cnt1), .err_overrun(err1)
   );

   cart_upload #(.MEM_LAT(3)) u_lat3 (
      .clk(clk), .reset(reset),
      .ioctl_upload(upload), .ioctl_rd(rd), .ioctl_addr(addr),
      .ioctl_din(din3), .ioctl_wait(wait3),
      .mem_addr(maddr3), .mem_rd(mrd3), .mem_dout(mdout3),
      .mem_busy(busy), .byte_count(cnt3), .err_overrun(err3)
   );

   function automatic logic [7:0] ramf(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h4A;
   endfunction

   // RAM models: data valid MEM_LAT cycles after mem_rd, junk otherwise
   always @(posedge clk) begin
      a1 <= mrd1 ? ramf(maddr1) : 8'hEE;
      b1 <= mrd3 ? ramf(maddr3) : 8'hEE;
      b2 <= b1;
      b3 <= b2;
   end
   assign mdout1 = a1;
   assign mdout3 = b3;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [15:0] a, input int nbusy,
                          input bit poke);
      int r1, r3, d1, d3;
      logic [15:0] ma1, ma3;
      logic [7:0]  v1, v3;
      bit oor;
      oor = (a >= 16'h4000);
      r1 = -1; r3 = -1; d1 = -1; d3 = -1;
      ma1 = '0; ma3 = '0; v1 = '0; v3 = '0;
      step();
      rd = 1'b1; addr = a; busy = 1'b0;
      #1;
      for (int k = 1; k <= 40; k++) begin
         step();
         rd   = poke && (k == 1);
         addr = ~a;
         busy = (k <= nbusy);
         #1;
         if (mrd1 && r1 < 0) begin r1 = k; ma1 = maddr1; end
         if (mrd3 && r3 < 0) begin r3 = k; ma3 = maddr3; end
         if (!wait1 && d1 < 0) begin d1 = k; v1 = din1; end
         if (!wait3 && d3 < 0) begin d3 = k; v3 = din3; end
         if (d1 >= 0 && d3 >= 0) break;
      end
      rd = 1'b0; busy = 1'b0;
      exp_cnt++;
      check("rd_cyc1", 32'(r1), oor ? -1 : 32'(nbusy + 1));
      check("rd_cyc3", 32'(r3), oor ? -1 : 32'(nbusy + 1));
      if (!oor) begin
         check("maddr1", 32'(ma1), 32'(a));
         check("maddr3", 32'(ma3), 32'(a));
      end
      check("done1", 32'(d1), oor ? 1 : 32'(nbusy + 3));
      check("done3", 32'(d3), oor ? 1 : 32'(nbusy + 5));
      check("din1", 32'(v1), oor ? 32'hFF : 32'(ramf(a)));
      check("din3", 32'(v3), oor ? 32'hFF : 32'(ramf(a)));
      check("cnt1", 32'(cnt1), 32'(exp_cnt));
      check("cnt3", 32'(cnt3), 32'(exp_cnt));
      if (poke) begin
         check("ovr1", 32'(err1), 32'd1);
         check("ovr3", 32'(err3), 32'd1);
      end
   endtask

   initial begin
      bit seen;
      bit got;
      logic [7:0] p1, p3;

      // reset held with strobes toggling
      seen = 1'b0;
      upload = 1'b1;
      addr = 16'h0010;
      for (int i = 0; i < 6; i++) begin
         step();
         rd = ~rd;
         #1;
         if (mrd1 || mrd3) seen = 1'b1;
      end
      rd = 1'b0;
      check("rst_mrd_seen", 32'(seen), 32'd0);
      check("rst_din1", 32'(din1), 32'd0);
      check("rst_din3", 32'(din3), 32'd0);
      check("rst_wait1", 32'(wait1), 32'd0);
      check("rst_wait3", 32'(wait3), 32'd0);
      check("rst_maddr1", 32'(maddr1), 32'd0);
      check("rst_cnt1", 32'(cnt1), 32'd0);
      check("rst_cnt3", 32'(cnt3), 32'd0);
      check("rst_err1", 32'(err1), 32'd0);
      step();
      reset = 1'b1;
      step();
      step();

      // basic read, contention, range edges
      do_read(16'h0010, 0, 1'b0);
      check("err1_clean", 32'(err1), 32'd0);
      do_read(16'h1234, 5, 1'b0);
      do_read(16'h4000, 0, 1'b0);
      do_read(16'hFFFF, 0, 1'b0);
      do_read(16'h3FFF, 0, 1'b0);

      // overrun: second strobe during wait
      do_read(16'h0200, 0, 1'b1);

      // abort mid-latency
      p1 = din1;
      p3 = din3;
      step();
      rd = 1'b1; addr = 16'h0123;
      step();
      rd = 1'b0;
      step();
      upload = 1'b0;
      step();
      #1;
      check("abort_wait1", 32'(wait1), 32'd0);
      check("abort_wait3", 32'(wait3), 32'd0);
      for (int i = 0; i < 4; i++) step();
      check("abort_din1", 32'(din1), 32'(p1));
      check("abort_din3", 32'(din3), 32'(p3));
      check("abort_cnt1", 32'(cnt1), 32'(exp_cnt));
      check("abort_cnt3", 32'(cnt3), 32'(exp_cnt));

      // new session clears count and flag
      upload = 1'b1;
      step();
      #1;
      exp_cnt = 0;
      check("sess_cnt1", 32'(cnt1), 32'd0);
      check("sess_cnt3", 32'(cnt3), 32'd0);
      check("sess_err1", 32'(err1), 32'd0);
      check("sess_err3", 32'(err3), 32'd0);

      // full-cartridge stream, paced by the MEM_LAT=1 instance
      step();
      rd = 1'b1; addr = 16'h0000;
      #1;
      for (int i = 0; i < 16384; i++) begin
         got = 1'b0;
         for (int k = 1; k <= 10; k++) begin
            step();
            rd = 1'b0;
            #1;
            if (!wait1) begin got = 1'b1; break; end
         end
         if (!got) begin
            check("stream_timeout", 32'(i), 32'hFFFFFFFF);
            break;
         end
         check("stream_din", 32'(din1), 32'(ramf(16'(i))));
         if (miscompares > 50) break;
         if (i < 16383) begin
            rd = 1'b1;
            addr = 16'(i + 1);
         end
      end
      rd = 1'b0;
      step();
      #1;
      check("stream_cnt", 32'(cnt1), 32'd16384);
      check("stream_err", 32'(err1), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
